// File: rtl/qupls_regfile_nwnr_if.sv
// Port bundle for the multi-write/multi-read register file: write ports, read
// addresses, registered read data and status.
interface qupls_regfile_nwnr_if #(
  parameter int WID   = 64,
  parameter int PREGS = 512,
  parameter int NWR   = 4,
  parameter int NRD   = 18
);
  localparam int AW = $clog2(PREGS);

  logic [NWR-1:0]          wr;
  logic [NWR-1:0][AW-1:0]  wa;
  logic [NWR-1:0][WID-1:0] i;
  logic [NRD-1:0][AW-1:0]  ra;
  logic [NRD-1:0][WID-1:0] o;
  logic                    busy;
  logic                    wcoll;
  logic [15:0]             wcoll_cnt;

  modport master (output wr, wa, i, ra, input o, busy, wcoll, wcoll_cnt);
  modport slave  (input wr, wa, i, ra, output o, busy, wcoll, wcoll_cnt);
endinterface

// File: rtl/qupls_regfile_nwnr.sv
// NWR-write / NRD-read register file built from NWR x NRD dual-port banks with a
// live value table selecting the most recent writer; cleared by a reset sweep.
module qupls_regfile_nwnr #(
  parameter int WID   = 64,
  parameter int PREGS = 512,
  parameter int NWR   = 4,
  parameter int NRD   = 18
) (
  input  logic                  clk,
  input  logic                  rst,
  qupls_regfile_nwnr_if.slave   bus
);
  localparam int AW = $clog2(PREGS);
  localparam int LW = (NWR > 1) ? $clog2(NWR) : 1;

  typedef enum logic {CLEAR = 1'b0, RUN = 1'b1} state_e;

  state_e                        state_q, state_d;
  logic [AW-1:0]                 ptr_q, ptr_d;
  logic                          clr_we;
  logic [NWR-1:0]                we;
  logic [LW-1:0]                 lvt_q [PREGS];
  logic [NWR-1:0][NRD-1:0][WID-1:0] bank_rd;
  logic [LW-1:0]                 rd_sel [NRD];
  logic [NRD-1:0][WID-1:0]       o_d, o_q;
  logic                          wcoll_d, wcoll_q;
  logic [15:0]                   wcoll_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CLEAR;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      CLEAR: begin
        ptr_d = ptr_q + AW'(1);
        if (ptr_q == AW'(PREGS - 1)) begin
          state_d = RUN;
        end else begin
          state_d = CLEAR;
        end
      end
      RUN:     state_d = RUN;
      default: state_d = CLEAR;
    endcase
  end

  // Writes to r0 never commit, so r0 reads zero from every bank path.
  always_comb begin
    clr_we = (state_q == CLEAR) && !rst;
    we     = '0;
    for (int w = 0; w < NWR; w++) begin
      we[w] = (state_q == RUN) && !rst && bus.wr[w] && (bus.wa[w] != '0);
    end
  end

  // Ascending loop leaves the highest-numbered colliding port in the table.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      lvt_q[ptr_q] <= '0;
    end else begin
      for (int w = 0; w < NWR; w++) begin
        if (we[w]) lvt_q[bus.wa[w]] <= LW'(w);
      end
    end
  end

  for (genvar gw = 0; gw < NWR; gw++) begin : g_wr
    for (genvar gr = 0; gr < NRD; gr++) begin : g_rd
      logic [WID-1:0] mem_q [PREGS];

      always_ff @(posedge clk) begin
        if (clr_we) begin
          mem_q[ptr_q] <= '0;
        end else if (we[gw]) begin
          mem_q[bus.wa[gw]] <= bus.i[gw];
        end
      end

      assign bank_rd[gw][gr] = mem_q[bus.ra[gr]];
    end
  end

  // Bank data picked by the LVT, overridden by same-cycle writes (highest port last).
  always_comb begin
    o_d = '0;
    for (int k = 0; k < NRD; k++) begin
      rd_sel[k] = lvt_q[bus.ra[k]];
      for (int w = 0; w < NWR; w++) begin
        if (rd_sel[k] == LW'(w)) o_d[k] = bank_rd[w][k];
      end
      for (int w = 0; w < NWR; w++) begin
        if (we[w] && (bus.wa[w] == bus.ra[k])) o_d[k] = bus.i[w];
      end
      if ((bus.ra[k] == '0) || (state_q != RUN)) o_d[k] = '0;
    end
  end

  always_comb begin
    wcoll_d = 1'b0;
    for (int w = 0; w < NWR; w++) begin
      for (int v = w + 1; v < NWR; v++) begin
        if (we[w] && we[v] && (bus.wa[w] == bus.wa[v])) wcoll_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      o_q         <= '0;
      wcoll_q     <= 1'b0;
      wcoll_cnt_q <= 16'd0;
    end else begin
      o_q     <= o_d;
      wcoll_q <= wcoll_d;
      if (wcoll_d && (wcoll_cnt_q != 16'hFFFF)) wcoll_cnt_q <= wcoll_cnt_q + 16'd1;
    end
  end

  assign bus.o         = o_q;
  assign bus.busy      = (state_q == CLEAR);
  assign bus.wcoll     = wcoll_q;
  assign bus.wcoll_cnt = wcoll_cnt_q;
endmodule

// File: doc/qupls_regfile_nwnr.md
QUPLS_REGFILE_NWNR -- requirements
Module: qupls_regfile_nwnr

Interface
REQ-001 SHALL have parameter WID, 64: data width in bits.
REQ-002 SHALL have parameter PREGS, 512: physical register count; power of two, 64..1024.
REQ-003 SHALL have parameter NWR, 4: write port count, 1..8.
REQ-004 SHALL have parameter NRD, 18: read port count, 1..32.
REQ-005 SHALL derive AW = clog2(PREGS) and LW = max(1, clog2(NWR)) as local parameters.
REQ-006 SHALL have port clk  in  1: single clock; all state on rising edge.
REQ-007 SHALL have port rst  in  1: reset, synchronous, active-high.
REQ-008 SHALL have port wr  in  [NWR] x 1: write enable per write port.
REQ-009 SHALL have port wa  in  [NWR] x AW: write address per write port.
REQ-010 SHALL have port i  in  [NWR] x WID: write data per write port.
REQ-011 SHALL have port ra  in  [NRD] x AW: read address per read port.
REQ-012 SHALL have port o  out  [NRD] x WID: registered read data per read port.
REQ-013 SHALL have port busy  out  1: high while the clear sweep runs; writes and reads are blocked.
REQ-014 SHALL have port wcoll  out  1: one-cycle pulse flagging a same-address write collision.
REQ-015 SHALL have port wcoll_cnt  out  16: saturating collision-cycle count.

Function
REQ-016 SHALL store data in NWR x NRD simple dual-port banks with no reset on the memory arrays; bank (w,r) is written only by port w and read only by port r.
REQ-017 SHALL keep a live value table (LVT) of PREGS entries x LW bits recording the last write port per address.
REQ-018 SHALL have FSM states CLEAR and RUN only; rst forces CLEAR with sweep pointer ptr=0.
REQ-019 SHALL, in CLEAR, each cycle write zero to address ptr in every bank, set LVT[ptr]=0, and increment ptr.
REQ-020 SHALL go CLEAR->RUN on the edge where ptr==PREGS-1 is written; busy is high for exactly PREGS cycles after rst falls.
REQ-021 SHALL ignore wr in CLEAR, force o to zero, and hold wcoll low.
REQ-022 SHALL commit, in RUN, each write with wr[w]=1 and wa[w]!=0 at the edge ending that cycle, and set LVT[wa[w]]=w.
REQ-023 SHALL discard writes to address 0; register 0 is hardwired zero.
REQ-024 SHALL resolve same-address writes in one cycle to the highest-numbered port, for both data and LVT.
REQ-025 SHALL have read latency 1: o[k] at cycle t+1 reflects ra[k] sampled at cycle t.
REQ-026 SHALL include all writes committed at the end of cycle t in o[k]; same-cycle writes are forwarded with highest-port priority, bypassing the RAM.
REQ-027 SHALL otherwise drive o[k] from bank (LVT[ra[k]], k).
REQ-028 SHALL return zero for ra[k]==0 regardless of any write.
REQ-029 SHALL, in RUN, pulse wcoll at t+1 when two or more ports write the same non-zero address in cycle t.
REQ-030 SHALL increment wcoll_cnt by 1 per collision cycle, regardless of how many ports collide, and saturate at 0xFFFF.
REQ-031 SHALL set o, if reads in adjacent cycles hit the same address, per REQ-026 with no hazard window.

Reset
REQ-032 SHALL set, on rst, o=0 for all ports, busy=1, wcoll=0, wcoll_cnt=0, ptr=0, state=CLEAR.
REQ-033 SHALL restart the sweep from ptr=0 when rst is asserted mid-sweep; busy stays high PREGS cycles after the final rst release.
REQ-034 SHALL guarantee that no pre-reset register contents are visible after busy falls; all reads return 0 until rewritten.

Verification
REQ-035 SHALL cover clear: write 0x55 to addr 7, pulse rst 1 cycle -> busy high exactly 512 cycles, then ra[0]=7 -> o[0]=0.
REQ-036 SHALL cover forward: port 2 writes 0x1234 to addr 5 at cycle t, ra[0]=5 at t -> o[0]=0x1234 at t+1; ra[3]=5 at t+1 -> o[3]=0x1234 at t+2 via LVT.
REQ-037 SHALL cover collision: ports 1 and 3 write addr 9 with 0xA and 0xB in one cycle -> reads return 0xB, wcoll high 1 cycle, wcoll_cnt 0->1.
REQ-038 SHALL cover r0: port 0 writes 0xFFFF to addr 0, ports 0 and 1 both write addr 0 -> reads of 0 return 0, wcoll stays 0.
REQ-039 SHALL cover LVT sequence: addr 7 written 0x1 by port 0, then 0x2 by port 3, then 0x3 by port 0 on consecutive cycles -> read returns 0x3.
REQ-040 SHALL cover busy: rst reasserted at ptr=100 and wr asserted during busy -> busy high 512 cycles after release, written addresses read 0.
